// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for uart_param_core.
//   rx_state_e / tx_state_e : receiver / transmitter FSM states
//   uart_div_f              : clock cycles per oversample tick
//   uart_cnt_w_f            : counter width for a 0..n-1 counter (never 0)
// Macro UART_PARITY_EN adds the PARITY state to both enums.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
`endif

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_BIT_W      = $clog2(DEF_DATA_BITS);
  localparam int DEF_OS_W       = $clog2(DEF_OVERSAMPLE);

  function automatic int uart_div_f(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic int uart_cnt_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: parallel side of uart_param_core.
//   tx_data/tx_valid -> core, tx_ready/tx_busy <- core
//   rx_data/rx_valid/rx_frame_err/rx_parity_err <- core
// master = user logic (FIFO/counters), slave = the UART core.
interface uart_if #(parameter int DATA_BITS = 8) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick: free-running oversample tick generator.
//   clk, rst : system clock, async active-high reset
//   tick_o   : one-cycle pulse every DIV = CLK_HZ/(BAUD*OVERSAMPLE) cycles
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int DIV = uart_div_f(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = uart_cnt_w_f(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART.
//   clk, rst : system clock, async active-high reset
//   rx_i     : serial input (asynchronous, synchronised here)
//   tx_o     : serial output, registered, idles high
//   bus      : uart_if.slave -- tx ready/valid handshake, rx results
// Optional feature: define UART_PARITY_EN for one parity bit per frame
// (odd when PARITY_ODD=1, even otherwise). Without it rx_parity_err is 0.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rx_i,
  output logic   tx_o,
  uart_if.slave  bus
);
  localparam int OS_W = uart_cnt_w_f(OVERSAMPLE);
  localparam int BIT_W = uart_cnt_w_f(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
  // PARITY_ODD has no effect without parity support.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  logic tick;

  uart_os_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // ---------------- RX synchroniser + edge detect ----------------
  logic rx_meta_q, rxs_q, rxs_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      rxs_dly_q <= rxs_q;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e            rx_st_q;
  logic [OS_W-1:0]      rx_os_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q, rx_data_q;
  logic                 rx_valid_q, rx_ferr_q;
  logic                 rx_sample;
`ifdef UART_PARITY_EN
  logic                 rx_pbad_q, rx_perr_q;
`endif

  assign rx_sample = tick && (rx_os_q == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q    <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pbad_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      if (tick && rx_st_q != RX_IDLE)
        rx_os_q <= (rx_os_q == OS_LAST) ? '0 : rx_os_q + 1'b1;
      case (rx_st_q)
        RX_IDLE: begin
          if (rxs_dly_q && !rxs_q) begin
            rx_os_q <= '0;
            rx_st_q <= RX_START;
          end
        end
        RX_START: begin
          // Mid start bit: a high line here means the edge was a glitch.
          if (tick && rx_os_q == OS_HALF) begin
            rx_os_q  <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rxs_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_sh_q  <= {rxs_q, rx_sh_q[DATA_BITS-1:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_st_q <= RX_PARITY;
`else
              rx_st_q <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_sample) begin
            rx_pbad_q <= rxs_q != ((^rx_sh_q) ^ PAR_ODD);
            rx_st_q   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          // Leave at mid-stop so the next falling edge is caught promptly.
          if (rx_sample) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_sh_q;
            rx_ferr_q  <= !rxs_q;
`ifdef UART_PARITY_EN
            rx_perr_q  <= rx_pbad_q;
`endif
            rx_st_q    <= RX_IDLE;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = rx_perr_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  // ---------------- TX FSM ----------------
  tx_state_e            tx_st_q;
  logic [OS_W-1:0]      tx_os_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_stop_q;
  logic                 tx_q, tx_ready_q, tx_busy_q;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_bit_end = tick && (tx_os_q == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q    <= TX_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tick && tx_st_q != TX_IDLE)
        tx_os_q <= (tx_os_q == OS_LAST) ? '0 : tx_os_q + 1'b1;
      case (tx_st_q)
        TX_IDLE: begin
          // Tick phase is not realigned here, so the start bit may be short.
          if (bus.tx_valid && tx_ready_q) begin
            tx_sh_q    <= bus.tx_data;
`ifdef UART_PARITY_EN
            tx_par_q   <= (^bus.tx_data) ^ PAR_ODD;
`endif
            tx_os_q    <= '0;
            tx_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_st_q    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_bit_q <= '0;
            tx_st_q  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_q      <= tx_par_q;
              tx_st_q   <= TX_PARITY;
`else
              tx_q      <= 1'b1;
              tx_stop_q <= 1'b0;
              tx_st_q   <= TX_STOP;
`endif
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_q      <= 1'b1;
            tx_stop_q <= 1'b0;
            tx_st_q   <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop_q == STOP_LAST) begin
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              tx_st_q    <= TX_IDLE;
            end else begin
              tx_stop_q <= 1'b1;
            end
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = tx_busy_q;
endmodule

// File: tb/tb_uart_param_core.sv
module tb_uart_param_core;
  localparam int OS     = 16;
  localparam int DIV    = 4;
  localparam int BAUD   = 9600;
  localparam int CLK_HZ = BAUD * OS * DIV;
  localparam int BT     = OS * DIV;          // clock cycles per bit
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NA = 1 + 8 + PB + 1;        // bits per frame, instance A (8 data, 1 stop)
  localparam int NB = 1 + 9 + PB + 2;        // bits per frame, instance B (9 data, 2 stop)

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  rx_exp_t    rxq_a[$], rxq_b[$];
  logic [8:0] txq_a[$], txq_b[$];
  int         rxv_a = 0, rxv_b = 0;
  logic [8:0] last_a = '0;
  bit         txmon_a_en = 1'b1;

  // instance A: 8N1 (parity even when enabled), rx selectable loopback/bench-driven
  uart_if #(.DATA_BITS(8)) ifa ();
  logic tx_a, rx_a, rx_drv, loop_a;
  assign rx_a = loop_a ? tx_a : rx_drv;

  uart_param_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a), .tx_o(tx_a), .bus(ifa.slave)
  );

  // instance B: 9 data bits, 2 stop bits (odd parity when enabled), fixed loopback
  uart_if #(.DATA_BITS(9)) ifb ();
  logic tx_b;

  uart_param_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(9), .STOP_BITS(2), .PARITY_ODD(1)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_i(tx_b), .tx_o(tx_b), .bus(ifb.slave)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // ---------------- RX scoreboard monitors ----------------
  rx_exp_t ea, eb;

  always @(negedge clk) begin
    if (!rst && ifa.rx_valid) begin
      rxv_a++;
      if (rxq_a.size() == 0) fail("rx_a unexpected rx_valid");
      else begin
        ea = rxq_a.pop_front();
        last_a = ea.data;
        check("rx_a data", {23'd0, ifa.rx_data}, {23'd0, ea.data});
        check("rx_a frame_err", {31'd0, ifa.rx_frame_err}, {31'd0, ea.fe});
        check("rx_a parity_err", {31'd0, ifa.rx_parity_err}, {31'd0, ea.pe});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.rx_valid) begin
      rxv_b++;
      if (rxq_b.size() == 0) fail("rx_b unexpected rx_valid");
      else begin
        eb = rxq_b.pop_front();
        check("rx_b data", {23'd0, ifb.rx_data}, {23'd0, eb.data});
        check("rx_b frame_err", {31'd0, ifb.rx_frame_err}, {31'd0, eb.fe});
        check("rx_b parity_err", {31'd0, ifb.rx_parity_err}, {31'd0, eb.pe});
      end
    end
  end

  // ---------------- TX line decoders ----------------
  function automatic logic line(input int inst);
    return (inst != 0) ? tx_b : tx_a;
  endfunction

  task automatic tx_decode(input int inst, input int nb, input int ns, input bit podd);
    logic [8:0] d;
`ifdef UART_PARITY_EN
    logic p;
`endif
    d = '0;
    repeat (BT / 2) @(negedge clk);
    check("tx start bit", {31'd0, line(inst)}, 32'd0);
    for (int i = 0; i < nb; i++) begin
      repeat (BT) @(negedge clk);
      d[i] = line(inst);
    end
`ifdef UART_PARITY_EN
    repeat (BT) @(negedge clk);
    p = line(inst);
    check("tx parity bit", {31'd0, p}, {31'd0, (^d) ^ podd});
`else
    if (podd) d = d;
`endif
    for (int s = 0; s < ns; s++) begin
      repeat (BT) @(negedge clk);
      check("tx stop bit", {31'd0, line(inst)}, 32'd1);
    end
    if (inst == 0) begin
      if (txq_a.size() == 0) fail("tx_a unexpected frame");
      else check("tx_a line data", {23'd0, d}, {23'd0, txq_a.pop_front()});
    end else begin
      if (txq_b.size() == 0) fail("tx_b unexpected frame");
      else check("tx_b line data", {23'd0, d}, {23'd0, txq_b.pop_front()});
    end
  endtask

  initial forever begin
    @(negedge tx_a);
    if (txmon_a_en && !rst) tx_decode(0, 8, 1, 1'b0);
  end

  initial forever begin
    @(negedge tx_b);
    if (!rst) tx_decode(1, 9, 2, 1'b1);
  end

  // ---------------- tx_ready low-time measurement ----------------
  // Start bit may be short by up to one tick (DIV-1 cycles).
  int lowc_a = 0, lowc_b = 0;

  always @(negedge clk) begin
    if (rst) lowc_a = 0;
    else if (!ifa.tx_ready) lowc_a++;
    else if (lowc_a != 0) begin
      check_range("tx_a ready low cycles", lowc_a, NA * BT - DIV + 1, NA * BT);
      check("tx_a busy clear", {31'd0, ifa.tx_busy}, 32'd0);
      lowc_a = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) lowc_b = 0;
    else if (!ifb.tx_ready) lowc_b++;
    else if (lowc_b != 0) begin
      check_range("tx_b ready low cycles", lowc_b, NB * BT - DIV + 1, NB * BT);
      lowc_b = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!ifa.tx_ready && t < 4000) begin @(negedge clk); t++; end
    if (t >= 4000) fail("tx_a ready timeout");
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    txq_a.push_back({1'b0, d});
    if (loop_a) rxq_a.push_back('{data: {1'b0, d}, fe: 1'b0, pe: 1'b0});
    check("tx_a ready after accept", {31'd0, ifa.tx_ready}, 32'd0);
    check("tx_a busy after accept", {31'd0, ifa.tx_busy}, 32'd1);
  endtask

  task automatic send_b(input logic [8:0] d);
    int t = 0;
    @(negedge clk);
    while (!ifb.tx_ready && t < 4000) begin @(negedge clk); t++; end
    if (t >= 4000) fail("tx_b ready timeout");
    ifb.tx_data  = d;
    ifb.tx_valid = 1'b1;
    @(negedge clk);
    ifb.tx_valid = 1'b0;
    txq_b.push_back(d);
    rxq_b.push_back('{data: d, fe: 1'b0, pe: 1'b0});
    check("tx_b busy after accept", {31'd0, ifb.tx_busy}, 32'd1);
  endtask

  task automatic drain(input int inst);
    int t = 0;
    while (t < 6000 && ((inst == 0) ? (rxq_a.size() + txq_a.size())
                                    : (rxq_b.size() + txq_b.size())) != 0) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) fail((inst == 0) ? "drain_a timeout" : "drain_b timeout");
  endtask

  task automatic handshake_a();
    logic [7:0] seq [3];
    int idx = 0, t = 0;
    seq = '{8'h3C, 8'h3C, 8'hC3};
    ifa.tx_data  = seq[0];
    ifa.tx_valid = 1'b1;
    while (idx < 3 && t < 8000) begin
      @(negedge clk);
      t++;
      if (ifa.tx_ready) begin
        txq_a.push_back({1'b0, seq[idx]});
        rxq_a.push_back('{data: {1'b0, seq[idx]}, fe: 1'b0, pe: 1'b0});
        @(negedge clk);
        check("hs ready drops", {31'd0, ifa.tx_ready}, 32'd0);
        idx++;
        if (idx < 3) ifa.tx_data = seq[idx];
        else ifa.tx_valid = 1'b0;
      end
    end
    ifa.tx_valid = 1'b0;
    check("hs accept count", idx, 3);
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx_a(input logic [7:0] d, input bit stopv, input bit pflip);
    rx_exp_t e;
    e.data = {1'b0, d};
    e.fe   = !stopv;
    e.pe   = 1'b0;
`ifdef UART_PARITY_EN
    e.pe   = pflip;
`endif
    rxq_a.push_back(e);
    hold_rx(1'b0, BT);
    for (int i = 0; i < 8; i++) hold_rx(d[i], BT);
`ifdef UART_PARITY_EN
    hold_rx((^d) ^ pflip, BT);
`else
    if (pflip) rx_drv = 1'b0;
`endif
    hold_rx(stopv, BT);
    hold_rx(1'b1, 2 * BT);
  endtask

  initial begin
    int snap;
    loop_a = 1'b1;
    rx_drv = 1'b1;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset tx_a", {31'd0, tx_a}, 32'd1);
    check("reset tx_ready_a", {31'd0, ifa.tx_ready}, 32'd1);
    check("reset tx_busy_a", {31'd0, ifa.tx_busy}, 32'd0);
    check("reset rx_valid_a", {31'd0, ifa.rx_valid}, 32'd0);
    check("reset rx_data_a", {24'd0, ifa.rx_data}, 32'd0);
    check("reset rx_frame_err_a", {31'd0, ifa.rx_frame_err}, 32'd0);
    check("reset rx_parity_err_a", {31'd0, ifa.rx_parity_err}, 32'd0);
    check("reset tx_b", {31'd0, tx_b}, 32'd1);
    check("reset tx_ready_b", {31'd0, ifb.tx_ready}, 32'd1);

    fork
      begin
        send_a(8'hA5);
        send_a(8'h00);
        send_a(8'hFF);
        repeat (6) send_a(8'($urandom));
        handshake_a();
        drain(0);
        loop_a = 1'b0;
        // glitch: 4 ticks low must not produce a frame
        snap = rxv_a;
        hold_rx(1'b0, 4 * DIV);
        hold_rx(1'b1, 4 * BT);
        check("glitch no rx_valid", rxv_a - snap, 0);
        // break: one frame with frame error, then silence while low
        snap = rxv_a;
        rxq_a.push_back('{data: 9'd0, fe: 1'b1, pe: 1'b0});
        hold_rx(1'b0, 20 * BT);
        check("break one rx_valid", rxv_a - snap, 1);
        hold_rx(1'b1, 2 * BT);
        check("break no retrigger", rxv_a - snap, 1);
        // bench-driven frames, random payload, stop and parity corruption
        drive_rx_a(8'h55, 1'b1, 1'b0);
        drive_rx_a(8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
          drive_rx_a(8'($urandom), ($urandom_range(3) != 0), 1'($urandom));
        drain(0);
        check("rx_a data held", {23'd0, ifa.rx_data}, {23'd0, last_a});
      end
      begin
        send_b(9'h1FF);
        repeat (4) send_b(9'($urandom));
        drain(1);
      end
    join

    // reset in the middle of a TX frame and a partial RX frame
    txmon_a_en = 1'b0;
    @(negedge clk);
    ifa.tx_data  = 8'h5A;
    ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    check("mid-frame tx low", {31'd0, tx_a}, 32'd0);
    snap = rxv_a;
    #2 rst = 1'b1;
    #1;
    check("async reset tx", {31'd0, tx_a}, 32'd1);
    check("async reset tx_ready", {31'd0, ifa.tx_ready}, 32'd1);
    check("async reset tx_busy", {31'd0, ifa.tx_busy}, 32'd0);
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15 * BT) @(negedge clk);
    check("no rx_valid after reset", rxv_a - snap, 0);
    check("rx_data cleared by reset", {24'd0, ifa.rx_data}, 32'd0);

    // recovery after reset
    txmon_a_en = 1'b1;
    loop_a = 1'b1;
    send_a(8'($urandom));
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
